// File: rtl/ram_pipe.sv
// ram_pipe: single-port synchronous SRAM behind a valid/ready request port.
//
// The block takes byte addresses, checks them for word alignment and range, and
// applies byte write strobes. Responses come back through a READ_LAT-deep
// pipeline, one in-order response per accepted request. With CLEAR_ON_RESET
// set, the array is zeroed one word per cycle after every reset before
// requests are accepted.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   req_valid  request present
//   req_ready  request can be accepted this cycle (RUN state only)
//   req_we     1 = write, 0 = read
//   req_addr   byte address
//   req_wdata  write data
//   req_wstrb  byte write enables, bit i covers bits [8i+7:8i]
//   rsp_valid  one-cycle response pulse, no backpressure
//   rsp_rdata  read data; 0 for writes and errors; held while rsp_valid = 0
//   rsp_err    request was misaligned or out of range
module ram_pipe #(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 3400,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [31:0]        req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    input  logic [WIDTH/8-1:0] req_wstrb,
    output logic               rsp_valid,
    output logic [WIDTH-1:0]   rsp_rdata,
    output logic               rsp_err
);

    localparam int NB = WIDTH / 8;
    localparam int B  = $clog2(NB);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Low address bits that must be zero for an aligned access (0 when WIDTH = 8).
    localparam logic [31:0] OFF_MASK = (32'd1 << B) - 32'd1;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] clr_cnt, clr_cnt_nxt;
    logic          clr_we;

    logic [31:0]   word_idx;
    logic [AW-1:0] widx;
    logic          addr_err;
    logic          accept;
    logic          wr_en;
    logic          rd_en;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [READ_LAT-1:0]            vld_pipe;
    logic [READ_LAT-1:0]            err_pipe;
    logic [READ_LAT-1:0][WIDTH-1:0] dat_pipe;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_RESET;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // The first edge out of reset already writes word 0, so the last word is
    // written on the DEPTH-th edge and req_ready rises right after it.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        case (state)
            ST_RESET: begin
                if (CLEAR_ON_RESET != 0) begin
                    clr_we      = 1'b1;
                    clr_cnt_nxt = clr_cnt + 1'b1;
                    state_nxt   = ST_CLEAR;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_cnt == AW'(DEPTH - 1)) begin
                    clr_cnt_nxt = '0;
                    state_nxt   = ST_RUN;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RESET;
            end
        endcase
    end

    assign req_ready = (state == ST_RUN);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign accept   = req_valid & req_ready;
    assign word_idx = req_addr >> B;
    assign addr_err = (|(req_addr & OFF_MASK)) | (word_idx >= 32'(DEPTH));
    assign widx     = word_idx[AW-1:0];
    assign wr_en    = accept & req_we & ~addr_err;
    assign rd_en    = accept & ~req_we & ~addr_err;

    // ------------------------------------------------------------------
    // Storage. No reset on the array itself; the clear walk zeroes it.
    // Clear and request writes never coincide because req_ready is low
    // outside RUN.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we) begin
                mem[clr_cnt] <= '0;
            end else if (wr_en) begin
                for (int b = 0; b < NB; b++) begin
                    if (req_wstrb[b]) begin
                        mem[widx][8*b +: 8] <= req_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline. Stage 0 captures at the accept edge, so a read
    // sees every write accepted on an earlier edge. Err/data of a stage
    // only move when a valid entry moves into it, which keeps the output
    // stage holding the last response while rsp_valid is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            err_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= accept;
            if (accept) begin
                err_pipe[0] <= addr_err;
                dat_pipe[0] <= rd_en ? mem[widx] : '0;
            end
            for (int s = 1; s < READ_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1]) begin
                    err_pipe[s] <= err_pipe[s-1];
                    dat_pipe[s] <= dat_pipe[s-1];
                end
            end
        end
    end

    assign rsp_valid = vld_pipe[READ_LAT-1];
    assign rsp_err   = err_pipe[READ_LAT-1];
    assign rsp_rdata = dat_pipe[READ_LAT-1];

endmodule

// File: tb/tb_ram_pipe.sv
// Testbench for ram_pipe.
// u_a: DEPTH=16, READ_LAT=3, CLEAR_ON_RESET=1 -> clear walk and back-to-back
//      pipelining, checked against hand-computed tables.
// u_b: DEPTH=3400, READ_LAT=4, CLEAR_ON_RESET=0 -> strobes, errors, reset
//      mid-stream and a random run, checked against a word-array model with
//      an expected-response queue.
module tb_ram_pipe;

    localparam int LAT_A = 3;
    localparam int DEP_A = 16;
    localparam int LAT_B = 4;
    localparam int DEP_B = 3400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_valid, a_ready, a_we;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_wstrb;
    logic        a_rsp_valid, a_rsp_err;

    logic        b_valid, b_ready, b_we;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_wstrb;
    logic        b_rsp_valid, b_rsp_err;

    ram_pipe #(.WIDTH(32), .DEPTH(DEP_A), .READ_LAT(LAT_A), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
        .req_addr(a_addr), .req_wdata(a_wdata), .req_wstrb(a_wstrb),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_rsp_err)
    );

    ram_pipe #(.WIDTH(32), .DEPTH(DEP_B), .READ_LAT(LAT_B), .CLEAR_ON_RESET(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_addr(b_addr), .req_wdata(b_wdata), .req_wstrb(b_wstrb),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_rsp_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;   // number of rising edges so far

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- model for u_b ----------------
    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mm [0:DEP_B-1];
    int          rsp_cnt   = 0;
    logic [31:0] last_data = '0;
    logic        last_err  = 1'b0;

    // Requests are driven on the falling edge and accepted on the next rising
    // edge E = cyc+1; the response is visible after edge E+LAT-1.
    task automatic b_req(input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] st);
        exp_t        e;
        logic [31:0] wi;
        bit          er;
        @(negedge clk);
        chk("b_req_ready", b_ready, 1'b1);
        b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; b_wstrb = st;
        wi = addr >> 2;
        er = (addr[1:0] != 2'b00) || (wi >= 32'(DEP_B));
        e.due  = cyc + LAT_B;
        e.err  = er;
        e.data = (!we && !er) ? mm[wi] : 32'h0;
        if (we && !er)
            for (int b = 0; b < 4; b++)
                if (st[b]) mm[wi][8*b +: 8] = wd[8*b +: 8];
        q.push_back(e);
    endtask

    task automatic b_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            b_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        q.delete();
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Compare process: every rsp_valid pulse of u_b must match the queue head
    // and arrive exactly on its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (b_rsp_valid === 1'b1) begin
            rsp_cnt++;
            last_data = b_rdata;
            last_err  = b_rsp_err;
            if (q.size() == 0 || q[0].due != cyc) begin
                n_cmp++; n_fail++;
                $display("FAIL rsp_unexpected: cycle %0d got rsp_valid=1, expected 0", cyc);
            end else begin
                e = q.pop_front();
                chk("rsp_err", b_rsp_err, e.err);
                chk("rsp_rdata", b_rdata, e.data);
            end
        end else if (q.size() != 0 && q[0].due == cyc) begin
            n_cmp++; n_fail++;
            $display("FAIL rsp_missing: cycle %0d got rsp_valid=0, expected 1", cyc);
            void'(q.pop_front());
        end
    end

    // ---------------- u_a directed tables ----------------
    // Read 0x3C, write 1 to 0x0, read 0x0, read 0x4, all back to back.
    bit          ta_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ta_addr [4] = '{32'h3C, 32'h0, 32'h0, 32'h4};
    logic [31:0] ta_wd   [4] = '{32'h0, 32'h1, 32'h0, 32'h0};
    // Expected response on falling edge i after the first drive (latency 3).
    bit          ea_vld  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] ea_dat  [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0};

    initial begin
        int          base;
        int          sel, pw;
        logic [31:0] addr;

        rst_n = 1'b0;
        a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_wstrb = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
        chk("rst_a_rsp_valid", a_rsp_valid, 1'b0);
        chk("rst_b_rsp_valid", b_rsp_valid, 1'b0);
        chk("rst_b_rdata", b_rdata, 32'h0);
        chk("rst_b_err", b_rsp_err, 1'b0);
        rst_n = 1'b1;

        // Clear walk: u_a ready only after the 16th edge; u_b ready at once.
        for (int k = 1; k <= DEP_A; k++) begin
            @(negedge clk);
            chk("a_ready_clear", a_ready, (k == DEP_A));
            if (k == 1) chk("b_ready_first", b_ready, 1'b1);
        end

        // Back-to-back on u_a
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 4) begin
                a_valid = 1'b1; a_we = ta_we[i]; a_addr = ta_addr[i];
                a_wdata = ta_wd[i]; a_wstrb = 4'hF;
            end else begin
                a_valid = 1'b0;
            end
            chk("a_pipe_valid", a_rsp_valid, ea_vld[i]);
            if (ea_vld[i]) begin
                chk("a_pipe_rdata", a_rdata, ea_dat[i]);
                chk("a_pipe_err", a_rsp_err, 1'b0);
            end
        end

        // Byte strobes on u_b
        b_req(1'b1, 32'h10, 32'hAABBCCDD, 4'hF);
        b_req(1'b1, 32'h10, 32'h11223344, 4'h5);
        b_req(1'b0, 32'h10, 32'h0, 4'h0);
        b_idle(LAT_B + 1);
        chk("strobe_rdata", last_data, 32'hAA22CC44);
        chk("strobe_err", last_err, 1'b0);
        chk("hold_valid", b_rsp_valid, 1'b0);
        chk("hold_rdata", b_rdata, 32'hAA22CC44);
        b_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
        b_req(1'b0, 32'h10, 32'h0, 4'h0);
        b_idle(LAT_B + 1);
        chk("zero_strobe_rdata", last_data, 32'hAA22CC44);

        // Errors
        b_req(1'b0, 32'h2, 32'h0, 4'h0);
        b_idle(LAT_B + 1);
        chk("misalign_err", last_err, 1'b1);
        chk("misalign_rdata", last_data, 32'h0);
        b_req(1'b1, 32'(3399 * 4), 32'hCAFEF00D, 4'hF);
        b_req(1'b1, 32'(3400 * 4), 32'hDEADBEEF, 4'hF);
        b_idle(LAT_B + 1);
        chk("range_err", last_err, 1'b1);
        b_req(1'b0, 32'(3399 * 4), 32'h0, 4'h0);
        b_idle(LAT_B + 1);
        chk("last_word_kept", last_data, 32'hCAFEF00D);

        // Reset mid-stream
        b_req(1'b1, 32'h20, 32'h5A5A1234, 4'hF);
        b_idle(LAT_B + 1);
        base = rsp_cnt;
        b_req(1'b0, 32'h20, 32'h0, 4'h0);
        b_req(1'b0, 32'h24, 32'h0, 4'h0);
        b_req(1'b0, 32'h28, 32'h0, 4'h0);
        do_reset(1);
        b_idle(LAT_B + 4);
        chk("no_rsp_after_reset", rsp_cnt - base, 0);
        b_req(1'b0, 32'h20, 32'h0, 4'h0);
        b_idle(LAT_B + 1);
        chk("data_kept_reset", last_data, 32'h5A5A1234);

        // Random run: seed a pool of words so every in-range read is defined.
        for (int w = 0; w < 64; w++) b_req(1'b1, 32'(w * 4), $urandom, 4'hF);
        for (int w = 3390; w < DEP_B; w++) b_req(1'b1, 32'(w * 4), $urandom, 4'hF);
        for (int n = 0; n < 10000; n++) begin
            sel = $urandom_range(0, 9);
            pw  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 63) : $urandom_range(3390, 3399);
            if (sel <= 6)      addr = 32'(pw * 4);
            else if (sel == 7) addr = 32'(pw * 4) + 32'($urandom_range(1, 3));
            else if (sel == 8) addr = 32'($urandom_range(3400, 3500) * 4);
            else               addr = $urandom | 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) b_idle(1);
            b_req($urandom_range(0, 1) != 0, addr, $urandom, 4'($urandom_range(0, 15)));
        end
        b_idle(LAT_B + 2);
        chk("all_responded", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_pipe.md
# ram_pipe

Parametrised single-port synchronous SRAM with a valid/ready request interface, byte write strobes, configurable read latency, address checking and an optional hardware clear after reset. It replaces the bare word-addressed RAM on the SoC data and instruction paths: the CPU load/store unit and the JPEG buffer master drive it with byte addresses. It accepts one request per cycle and returns exactly one in-order response per accepted request.

## Interface
- WIDTH, 32: data word width in bits; a multiple of 8, at least 8.
- DEPTH, 3400: number of words; at least 2.
- READ_LAT, 1: response latency in cycles, from 1 to 4.
- CLEAR_ON_RESET, 1: when 1, the whole array is zeroed after every reset.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  WIDTH  write data.
- req_wstrb  in  WIDTH/8  byte write enables; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  one-cycle response pulse; the block provides no backpressure.
- rsp_rdata  out  WIDTH  read data; 0 for writes and for errors.
- rsp_err  out  1  accepted request was misaligned or out of range.

## Operation
- Let B = log2(WIDTH/8). The word index is req_addr >> B; the offset is req_addr[B-1:0] (none when WIDTH = 8).
- The block accepts a request on a rising edge where req_valid = 1 and req_ready = 1.
- Error: the offset is nonzero, or the word index is at least DEPTH. On error the array is unchanged, rsp_err = 1 and rsp_rdata = 0.
- Write without error: at the accept edge, the block writes each byte whose strobe bit is 1. Unstrobed bytes keep their value. The response has rsp_err = 0 and rsp_rdata = 0. A write with req_wstrb = 0 is legal and leaves the array unchanged.
- Read without error: the block samples the array at the accept edge. A write accepted on an earlier edge is therefore visible to it, so no forwarding logic is needed.
- States:
  - RESET: while rst_n = 0.
  - CLEAR: entered on the first edge with rst_n = 1 when CLEAR_ON_RESET = 1. A counter runs 0 to DEPTH-1 and writes all-zero words, one word per cycle. The block moves to RUN after the edge that writes word DEPTH-1.
  - RUN: entered directly from RESET when CLEAR_ON_RESET = 0.
- req_ready is 1 only in RUN, and is driven combinationally from state.
- Response pipeline: READ_LAT stages of {valid, err, data}. It is fully pipelined, so back-to-back requests give back-to-back responses in acceptance order.

## Timing
- Reset values, while rst_n = 0 and on the first cycle after it:
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - req_ready = 0.
  - Clear counter = 0; all pipeline stages invalid.
- req_ready after reset:
  - CLEAR_ON_RESET = 0: 1 in the first cycle after rst_n rises.
  - CLEAR_ON_RESET = 1: 1 exactly DEPTH cycles after rst_n rises.
- Latency: for a request accepted at edge E, rsp_valid is 1 for exactly one cycle, following edge E + READ_LAT - 1. With READ_LAT = 1, the response appears in the cycle right after acceptance. Writes and reads use the same latency.
- Reset mid-operation:
  - In-flight responses are discarded and produce no rsp_valid pulse.
  - Array contents are kept when CLEAR_ON_RESET = 0.
  - Reset during CLEAR restarts the clear from word 0.
- rsp_rdata and rsp_err hold their last values while rsp_valid = 0. Only the rsp_valid = 1 cycles are meaningful.
- Array contents are undefined without a clear. Reading a never-written word with CLEAR_ON_RESET = 0 may return X in simulation.

## Test plan
- Clear sequence: DEPTH = 16, CLEAR_ON_RESET = 1; release reset.
  - req_ready is 0 for 16 cycles, then 1.
  - Read at address 0x3C → rsp_rdata = 0, rsp_err = 0.
- Byte strobes: WIDTH = 32.
  - Write 0xAABBCCDD to 0x10 with strobe 0xF; then write 0x11223344 with strobe 0x5.
  - Read 0x10 → 0xAA22CC44.
- Back-to-back pipelining: READ_LAT = 3.
  - Write 0x1 to 0x0, then read 0x0 and read 0x4 on the following consecutive cycles.
  - Responses arrive in 3 consecutive cycles after latency 3. The read of 0x0 returns 0x1.
- Errors: DEPTH = 3400.
  - Read 0x2 → rsp_err = 1, rsp_rdata = 0.
  - Write to byte address 3400*4 → rsp_err = 1; word 3399 is unchanged.
- Reset mid-stream: READ_LAT = 4.
  - Issue 3 reads, then drop rst_n for 1 cycle, 2 cycles after the first accept.
  - No rsp_valid pulse follows; with CLEAR_ON_RESET = 0, earlier written data is still readable.
- Random compare: 10k random requests with random strobes, including out-of-range addresses, checked against a reference model.
  - Every accepted request gets exactly one response.
  - Data and err match the model.
